// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: shares one synchronous data memory between the
// pipeline MEM stage (P, fixed priority) and an auxiliary master (A).
// A starvation counter forces one A grant after MAX_WAIT consecutive denials.
// Read data returns one cycle after the grant and is tagged to its issuer.
module dmem_port_arbiter #(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  // pipeline MEM-stage requester
  input  logic                  p_rd,
  input  logic                  p_wr,
  input  logic [DM_ADDRESS-1:0] p_addr,
  input  logic [DATA_W-1:0]     p_wdata,
  input  logic [2:0]            p_func3,
  output logic                  p_stall,
  output logic [DATA_W-1:0]     p_rdata,
  output logic                  p_rvalid,
  // auxiliary requester
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [DM_ADDRESS-1:0] a_addr,
  input  logic [DATA_W-1:0]     a_wdata,
  input  logic [2:0]            a_func3,
  output logic                  a_gnt,
  output logic [DATA_W-1:0]     a_rdata,
  output logic                  a_rvalid,
  // data memory side
  output logic                  m_rd,
  output logic                  m_wr,
  output logic [DM_ADDRESS-1:0] m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [2:0]            m_func3,
  input  logic [DATA_W-1:0]     m_rdata
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       rd_pend_q, rd_own_q;
  logic       p_req, force_a, grant_a, grant_p;
  logic       mem_rd;

  // Arbitration: P wins unless A has been starved for MaxWait cycles.
  always_comb begin
    p_req   = p_rd | p_wr;
    force_a = a_req & p_req & (wait_cnt_q == MaxWait);
    grant_a = a_req & (~p_req | force_a);
    grant_p = p_req & ~force_a;
  end

  // Memory request mux; a simultaneous P read+write is issued as a write.
  // Everything is forced low while reset is held so no access leaks out.
  always_comb begin
    mem_rd  = 1'b0;
    m_wr    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_func3 = '0;
    if (!reset) begin
      if (grant_p) begin
        mem_rd  = p_rd & ~p_wr;
        m_wr    = p_wr;
        m_addr  = p_addr;
        m_wdata = p_wdata;
        m_func3 = p_func3;
      end else if (grant_a) begin
        mem_rd  = ~a_we;
        m_wr    = a_we;
        m_addr  = a_addr;
        m_wdata = a_wdata;
        m_func3 = a_func3;
      end
    end
    m_rd = mem_rd;
  end

  // Handshake and read-return outputs, all held at zero during reset.
  always_comb begin
    p_stall  = 1'b0;
    a_gnt    = 1'b0;
    p_rvalid = 1'b0;
    a_rvalid = 1'b0;
    p_rdata  = '0;
    a_rdata  = '0;
    if (!reset) begin
      p_stall  = p_req & ~grant_p;
      a_gnt    = grant_a;
      p_rvalid = rd_pend_q & ~rd_own_q;
      a_rvalid = rd_pend_q & rd_own_q;
      p_rdata  = m_rdata;
      a_rdata  = m_rdata;
    end
  end

  // Starvation counter: counts only while A is held and denied.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (grant_a) begin
      wait_cnt_d = '0;
    end else if (a_req) begin
      if (wait_cnt_q < MaxWait) begin
        wait_cnt_d = wait_cnt_q + 4'd1;
      end
    end else begin
      wait_cnt_d = '0;
    end
  end

  // Registered state: starvation count and ownership of the pending read.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_own_q   <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rd_pend_q  <= mem_rd;
      rd_own_q   <= grant_a;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter with a behavioural data memory
// and a scoreboard of expected read returns (owner, data, due cycle).
module tb_dmem_port_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          p_rd = 1'b0, p_wr = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [DW-1:0] p_wdata = '0;
  logic [2:0]    p_func3 = '0;
  logic          p_stall, p_rvalid;
  logic [DW-1:0] p_rdata;
  logic          a_req = 1'b0, a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic [2:0]    a_func3 = '0;
  logic          a_gnt, a_rvalid;
  logic [DW-1:0] a_rdata;
  logic          m_rd, m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [2:0]    m_func3;
  logic [DW-1:0] m_rdata = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    bit          own_a;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  logic [31:0] mem [0:127];

  dmem_port_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .p_rd(p_rd), .p_wr(p_wr), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_func3(p_func3), .p_stall(p_stall), .p_rdata(p_rdata), .p_rvalid(p_rvalid),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_func3(a_func3), .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .m_rd(m_rd), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_func3(m_func3), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'hA500_0000 | i;
  end

  // word-addressed synchronous memory, one cycle read latency
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_wr) mem[m_addr[8:2]] <= m_wdata;
    if (m_rd) m_rdata <= mem[m_addr[8:2]];
  end

  // response monitor: pops the scoreboard on every rvalid
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due < cyc) begin
      checks++;
      failures++;
      $display("FAIL missing_rvalid: no response at cycle %0d, required owner_a=%0d data=%h", sb[0].due, sb[0].own_a, sb[0].data);
      void'(sb.pop_front());
    end
    if (p_rvalid || a_rvalid) begin
      checks++;
      if (p_rvalid && a_rvalid) begin
        failures++;
        $display("FAIL both_rvalid: p_rvalid=1 a_rvalid=1 at cycle %0d, required at most one", cyc);
      end else if (sb.size() == 0) begin
        failures++;
        $display("FAIL spurious_rvalid: p_rvalid=%0d a_rvalid=%0d at cycle %0d, required none", p_rvalid, a_rvalid, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (a_rvalid !== e.own_a || e.due !== cyc ||
            (e.own_a ? a_rdata : p_rdata) !== e.data) begin
          failures++;
          $display("FAIL read_return: got owner_a=%0d data=%h cycle=%0d, required owner_a=%0d data=%h cycle=%0d",
                   a_rvalid, (a_rvalid ? a_rdata : p_rdata), cyc, e.own_a, e.data, e.due);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, required completion");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    p_rd = 1'b0; p_wr = 1'b0; p_addr = '0; p_wdata = '0; p_func3 = '0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_func3 = '0;
  endtask

  task automatic push_exp(input bit own_a, input logic [31:0] d);
    exp_t e;
    e.own_a = own_a;
    e.data  = d;
    e.due   = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    tick();
    reset = 1'b1;
    p_rd = 1'b1; p_addr = 9'h010; p_func3 = 3'd2;
    a_req = 1'b1; a_addr = 9'h020; a_wdata = 32'h1111_2222;
    settle();
    checks++;
    if ({m_rd, m_wr, p_stall, a_gnt, p_rvalid, a_rvalid} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: m_rd/m_wr/p_stall/a_gnt/p_rvalid/a_rvalid=%b, required 000000",
               {m_rd, m_wr, p_stall, a_gnt, p_rvalid, a_rvalid});
    end
    checks++;
    if (m_addr !== '0 || m_wdata !== '0 || m_func3 !== '0 || p_rdata !== '0 || a_rdata !== '0) begin
      failures++;
      $display("FAIL reset_data: m_addr=%h m_wdata=%h m_func3=%0d p_rdata=%h a_rdata=%h, required all 0",
               m_addr, m_wdata, m_func3, p_rdata, a_rdata);
    end
    tick();
    idle();
    reset = 1'b0;
  endtask

  task automatic test_p_only();
    tick();
    p_wr = 1'b1; p_addr = 9'h010; p_wdata = 32'hDEAD_BEEF; p_func3 = 3'd2;
    settle();
    checks++;
    if (p_stall !== 1'b0 || m_wr !== 1'b1 || m_rd !== 1'b0 || m_addr !== 9'h010 ||
        m_wdata !== 32'hDEAD_BEEF || m_func3 !== 3'd2) begin
      failures++;
      $display("FAIL p_write: stall=%0d m_wr=%0d m_rd=%0d addr=%h wdata=%h f3=%0d, required 0 1 0 010 deadbeef 2",
               p_stall, m_wr, m_rd, m_addr, m_wdata, m_func3);
    end
    tick();
    p_wr = 1'b0; p_rd = 1'b1; p_wdata = '0;
    push_exp(1'b0, 32'hDEAD_BEEF);
    settle();
    checks++;
    if (p_stall !== 1'b0 || m_rd !== 1'b1 || m_wr !== 1'b0 || m_addr !== 9'h010) begin
      failures++;
      $display("FAIL p_read: stall=%0d m_rd=%0d m_wr=%0d addr=%h, required 0 1 0 010", p_stall, m_rd, m_wr, m_addr);
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_a_only();
    tick();
    a_req = 1'b1; a_we = 1'b0; a_addr = 9'h020; a_func3 = 3'd2;
    push_exp(1'b1, 32'hA500_0008);
    settle();
    checks++;
    if (a_gnt !== 1'b1 || m_rd !== 1'b1 || m_wr !== 1'b0 || m_addr !== 9'h020 || p_stall !== 1'b0) begin
      failures++;
      $display("FAIL a_read: gnt=%0d m_rd=%0d m_wr=%0d addr=%h stall=%0d, required 1 1 0 020 0",
               a_gnt, m_rd, m_wr, m_addr, p_stall);
    end
    tick();
    a_we = 1'b1; a_addr = 9'h040; a_wdata = 32'hCAFE_F00D;
    settle();
    checks++;
    if (a_gnt !== 1'b1 || m_wr !== 1'b1 || m_rd !== 1'b0 || m_wdata !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL a_write: gnt=%0d m_wr=%0d m_rd=%0d wdata=%h, required 1 1 0 cafef00d", a_gnt, m_wr, m_rd, m_wdata);
    end
    tick();
    a_we = 1'b0;
    push_exp(1'b1, 32'hCAFE_F00D);
    tick();
    idle();
    tick();
  endtask

  // P reads every cycle while A holds a read; A must win on its 5th cycle only
  task automatic contend_round(input logic [8:0] aaddr, input logic [31:0] adata, input string tag);
    for (int i = 1; i <= 5; i++) begin
      tick();
      p_rd = 1'b1; p_addr = 9'h010;
      a_req = 1'b1; a_we = 1'b0; a_addr = aaddr;
      if (i == 5) push_exp(1'b1, adata);
      else        push_exp(1'b0, 32'hDEAD_BEEF);
      settle();
      checks++;
      if (a_gnt !== (i == 5) || p_stall !== (i == 5) || m_addr !== ((i == 5) ? aaddr : 9'h010)) begin
        failures++;
        $display("FAIL %s_cycle%0d: a_gnt=%0d p_stall=%0d m_addr=%h, required %0d %0d %h",
                 tag, i, a_gnt, p_stall, m_addr, (i == 5), (i == 5), ((i == 5) ? aaddr : 9'h010));
      end
    end
  endtask

  task automatic test_contention();
    contend_round(9'h024, 32'hA500_0009, "contend1");
    contend_round(9'h028, 32'hA500_000A, "contend2");
    tick();
    a_req = 1'b0;
    push_exp(1'b0, 32'hDEAD_BEEF);
    settle();
    checks++;
    if (p_stall !== 1'b0 || a_gnt !== 1'b0 || m_rd !== 1'b1) begin
      failures++;
      $display("FAIL contend_release: p_stall=%0d a_gnt=%0d m_rd=%0d, required 0 0 1", p_stall, a_gnt, m_rd);
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_routing();
    tick();
    a_req = 1'b1; a_addr = 9'h02C;
    push_exp(1'b1, 32'hA500_000B);
    settle();
    checks++;
    if (a_gnt !== 1'b1) begin
      failures++;
      $display("FAIL route_a_gnt: a_gnt=%0d, required 1", a_gnt);
    end
    tick();
    a_req = 1'b0; a_addr = '0;
    p_rd = 1'b1; p_addr = 9'h010;
    push_exp(1'b0, 32'hDEAD_BEEF);
    settle();
    checks++;
    if (p_stall !== 1'b0 || a_rvalid !== 1'b1 || p_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL route_mid: p_stall=%0d a_rvalid=%0d p_rvalid=%0d, required 0 1 0", p_stall, a_rvalid, p_rvalid);
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    tick();
    p_rd = 1'b1; p_addr = 9'h010; a_req = 1'b1; a_addr = 9'h030;
    push_exp(1'b0, 32'hDEAD_BEEF);
    tick();
    tick();
    reset = 1'b1;
    settle();
    checks++;
    if ({m_rd, m_wr, p_stall, a_gnt, p_rvalid, a_rvalid} !== 6'b0 || p_rdata !== '0) begin
      failures++;
      $display("FAIL reset_mid: ctrl=%b p_rdata=%h, required 000000 00000000",
               {m_rd, m_wr, p_stall, a_gnt, p_rvalid, a_rvalid}, p_rdata);
    end
    tick();
    reset = 1'b0;
    idle();
    contend_round(9'h030, 32'hA500_000C, "post_reset");
    tick();
    idle();
    tick();
  endtask

  task automatic test_rd_wr_both();
    tick();
    p_rd = 1'b1; p_wr = 1'b1; p_addr = 9'h034; p_wdata = 32'h1234_5678;
    settle();
    checks++;
    if (m_wr !== 1'b1 || m_rd !== 1'b0 || m_wdata !== 32'h1234_5678 || p_stall !== 1'b0) begin
      failures++;
      $display("FAIL rdwr_both: m_wr=%0d m_rd=%0d wdata=%h stall=%0d, required 1 0 12345678 0",
               m_wr, m_rd, m_wdata, p_stall);
    end
    tick();
    idle();
    tick();
    p_rd = 1'b1; p_addr = 9'h034;
    push_exp(1'b0, 32'h1234_5678);
    tick();
    idle();
    tick();
  endtask

  initial begin
    idle();
    test_reset();
    test_p_only();
    test_a_only();
    test_contention();
    test_routing();
    test_reset_mid();
    test_rd_wr_both();
    tick();
    tick();
    settle();
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
